// File: rtl/hex_event_pkg.sv
`default_nettype none
// ============================================================================
// hex_event_pkg : record layout, beat geometry and reader FSM encoding shared
//                 by the hex event writer and reader.
// Rev 1.0
// ============================================================================
package hex_event_pkg;

  localparam int HEXES_PER_BEAT = 10;
  localparam int REC_W          = 64;
  localparam int BEAT_W         = HEXES_PER_BEAT * REC_W;
  localparam int IDX_W          = $clog2(HEXES_PER_BEAT + 1);

  typedef struct packed {
    logic signed [15:0] q;
    logic signed [15:0] r;
    logic [7:0]         depth;
    logic [7:0]         material;
    logic [15:0]        pad;
  } hex_rec_t;

  // Reader FSM encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_FLUSH = 3'd4;

endpackage
`default_nettype wire

// File: rtl/hex_beat_unpacker.sv
`default_nettype none
// ============================================================================
// hex_beat_unpacker : holds one memory beat, walks its records by index and
//                     flags the last valid record of the beat.
// Rev 1.0
// ============================================================================
module hex_beat_unpacker
  import hex_event_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [BEAT_W-1:0] beat_data,
  input  logic [IDX_W-1:0]  beat_n,
  output hex_rec_t          rec,
  output logic              last_in_beat
);

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  beat_n_q, beat_n_d;

  always_comb begin
    beat_d   = beat_q;
    idx_d    = idx_q;
    beat_n_d = beat_n_q;
    if (load) begin
      beat_d   = beat_data;
      idx_d    = '0;
      beat_n_d = beat_n;
    end else if (advance) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q   <= '0;
      idx_q    <= '0;
      beat_n_q <= '0;
    end else begin
      beat_q   <= beat_d;
      idx_q    <= idx_d;
      beat_n_q <= beat_n_d;
    end
  end

  always_comb begin
    rec = '0;
    for (int i = 0; i < HEXES_PER_BEAT; i++) begin
      if (idx_q == IDX_W'(i)) rec = beat_q[i*REC_W +: REC_W];
    end
  end

  // beat_n is never zero when loaded, so the subtraction cannot wrap in use
  assign last_in_beat = (idx_q == beat_n_q - 1'b1);

endmodule
`default_nettype wire

// File: rtl/hex_event_reader_10.sv
`default_nettype none
// ============================================================================
// hex_event_reader_10 : reads the 10-hex event buffer beat by beat and streams
//                       one hex record per cycle to the rasterizer.
// Optional: HEX_READ_PAD_CHECK_EN adds a sticky pad_error output.
// Rev 1.0
// ============================================================================
module hex_event_reader_10
  import hex_event_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] buffer_base,
  input  logic [ADDR_W-1:0] event_count,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_accept,
  input  logic              rd_valid,
  input  logic [BEAT_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_q,
  output logic [15:0]       out_r,
  output logic [7:0]        out_depth,
  output logic [7:0]        out_material,
  output logic              out_last,
  output logic              busy,
`ifdef HEX_READ_PAD_CHECK_EN
  output logic              pad_error,
`endif
  output logic              done
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic              done_q, done_d;
  logic [2:0]        restart_st;
  logic              load, advance, last_in_beat;
  logic [IDX_W-1:0]  beat_n_in;
  hex_rec_t          rec;

  assign beat_n_in = (remaining_q < ADDR_W'(HEXES_PER_BEAT)) ?
                     remaining_q[IDX_W-1:0] : IDX_W'(HEXES_PER_BEAT);

  // A zero-length frame completes at once instead of issuing a read
  assign restart_st = (event_count == '0) ? ST_IDLE : ST_REQ;

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    load        = 1'b0;
    advance     = 1'b0;
    if (frame_start) begin
      rd_ptr_d    = buffer_base;
      remaining_d = event_count;
      // An accepted read still owes a beat; it must be swallowed in FLUSH
      case (state_q)
        ST_REQ:   state_d = rd_accept ? ST_FLUSH : restart_st;
        ST_WAIT,
        ST_FLUSH: state_d = rd_valid ? restart_st : ST_FLUSH;
        default:  state_d = restart_st;
      endcase
      done_d = (state_d == ST_IDLE);
    end else begin
      case (state_q)
        ST_REQ: begin
          if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(HEXES_PER_BEAT);
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (rd_valid) begin
            load    = 1'b1;
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            advance     = 1'b1;
            remaining_d = remaining_q - 1'b1;
            if (last_in_beat) begin
              if (remaining_q == ADDR_W'(1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_REQ;
              end
            end
          end
        end
        ST_FLUSH: begin
          if (rd_valid) begin
            state_d = (remaining_q == '0) ? ST_IDLE : ST_REQ;
            done_d  = (remaining_q == '0);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  hex_beat_unpacker u_unpacker (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .advance      (advance),
    .beat_data    (rd_data),
    .beat_n       (beat_n_in),
    .rec          (rec),
    .last_in_beat (last_in_beat)
  );

  assign rd_req       = (state_q == ST_REQ);
  assign rd_addr      = rd_ptr_q;
  assign out_valid    = (state_q == ST_DRAIN);
  assign out_q        = out_valid ? rec.q        : '0;
  assign out_r        = out_valid ? rec.r        : '0;
  assign out_depth    = out_valid ? rec.depth    : '0;
  assign out_material = out_valid ? rec.material : '0;
  assign out_last     = out_valid && (remaining_q == ADDR_W'(1));
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;

`ifdef HEX_READ_PAD_CHECK_EN
  logic pad_error_q, pad_error_d;

  always_comb begin
    pad_error_d = pad_error_q;
    if (frame_start) pad_error_d = 1'b0;
    else if (out_valid && out_ready && (rec.pad != '0)) pad_error_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) pad_error_q <= 1'b0;
    else       pad_error_q <= pad_error_d;
  end

  assign pad_error = pad_error_q;
`else
  logic unused_pad;
  assign unused_pad = ^rec.pad;
`endif

endmodule
`default_nettype wire
